game_fsm: RTL and testbench
===========================

GAME_FSM -- requirements
Module: game_fsm

Interface
Parameters:
REQ-001 WIN_HITS, 17, number of ship-cell hits that wins a game, legal range 1..64.
Ports:
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle pulse that begins a game.
REQ-005 place_done_p1  input  1  pulse: player 1 fleet placement complete.
REQ-006 place_done_p2  input  1  pulse: player 2 fleet placement complete.
REQ-007 ship_map_p1  input  64  player 1 ship bitmap, bit index = y*8+x; held stable after place_done_p1.
REQ-008 ship_map_p2  input  64  player 2 ship bitmap, same indexing.
REQ-009 fire  input  1  pulse: the current player fires at (fire_x, fire_y).
REQ-010 fire_x  input  3  target column, sampled only when fire=1.
REQ-011 fire_y  input  3  target row, sampled only when fire=1.
REQ-012 state  output  3  game state code, consumed by the win-detect stage.
REQ-013 hit  output  1  one-cycle pulse: the last valid shot struck a ship cell.
REQ-014 miss  output  1  one-cycle pulse: the last valid shot struck water.
REQ-015 shot_reject  output  1  one-cycle pulse: the fire was ignored because the cell was already shot.
REQ-016 p1_hits  output  7  count of player 1 hits on player 2's fleet.
REQ-017 p2_hits  output  7  count of player 2 hits on player 1's fleet.

Function
REQ-018 State encoding shall be: 0 IDLE, 1 PLACE, 2 CHECK, 3 P1_TURN, 4 P2_TURN, 5 P1_WIN, 6 P2_WIN; code 7 is illegal and shall go to IDLE on the next edge.
REQ-019 IDLE: start=1 shall clear both shot bitmaps, both hit counters and both placement flags, and move to PLACE.
REQ-020 PLACE: each place_done_pN shall set its own sticky flag; both flags may be set in the same cycle.
REQ-021 PLACE shall go to P1_TURN on the edge after both flags are set.
REQ-022 In P1_TURN or P2_TURN, fire=1 on a cell not yet shot by that player shall register the cell index and shooter, set the shot bit, and move to CHECK.
REQ-023 In P1_TURN or P2_TURN, fire=1 on a cell already shot by that player shall pulse shot_reject for one cycle in the next cycle; the state and the turn shall not change.
REQ-024 CHECK shall last exactly one cycle and pulse exactly one of hit or miss, so the result appears 1 cycle after the fire edge.
REQ-025 On a hit, CHECK shall increment the shooter's counter by 1.
REQ-026 If the incremented count equals WIN_HITS, CHECK shall go to P1_WIN or P2_WIN for the shooter; otherwise it shall go to the opponent's turn.
REQ-027 A win shall take priority over a turn switch.
REQ-028 On a miss, CHECK shall go to the opponent's turn.
REQ-029 fire shall be ignored in IDLE, PLACE, CHECK, P1_WIN and P2_WIN; place_done pulses outside PLACE shall be ignored.
REQ-030 P1_WIN and P2_WIN shall hold until start=1, which shall behave exactly as REQ-019.
REQ-031 start outside IDLE, P1_WIN and P2_WIN shall be ignored.
REQ-032 Hit counters shall saturate at WIN_HITS and never wrap.

Reset
REQ-033 rst_n=0 shall asynchronously force: state=IDLE; hit, miss and shot_reject=0; p1_hits and p2_hits=0; shot bitmaps, placement flags and registered shot cleared.
REQ-034 Reset asserted mid-game, including in CHECK, shall discard the pending result with no hit or miss pulse.
REQ-035 After reset release, the block shall ignore fire until a new start and both placements.

Structure
REQ-036 A shared package shall hold the state codes, the grid constants (GRID_W=8, CELLS=64) and the cell-index function y*8+x.
REQ-037 One sub-module, shot_tracker, shall be instantiated once per player; it holds a 64-bit shot bitmap with clear, test and set ports.

Verification
REQ-038 Reset, then start, then place_done_p1 and place_done_p2 in the same cycle -> state 0 -> 1 -> 3.
REQ-039 In P1_TURN, fire at (2,3) with ship_map_p2 bit 26 = 1 -> one cycle later hit=1, state=2; then p1_hits=1 and state=4.
REQ-040 P1 fires at (0,0) twice, on its own turns, with a miss each time -> the second fire gives shot_reject=1, state stays 3, and no hit or miss pulse.
REQ-041 With WIN_HITS=2, P2 scores a second hit -> state=6 directly from CHECK; a later fire is ignored; start -> state=1 and both counters 0.
REQ-042 rst_n pulsed low during CHECK -> state=0 immediately, and no hit or miss pulse follows.
REQ-043 Force state code 7 -> state=0 on the next clock edge.

Source files
------------

// File: rtl/game_fsm_pkg.sv
// Shared definitions for the two-player battleship game controller:
// state codes, grid geometry and cell indexing.
package game_fsm_pkg;

   localparam int GRID_W = 8;
   localparam int CELLS  = 64;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PLACE   = 3'd1,
      S_CHECK   = 3'd2,
      S_P1_TURN = 3'd3,
      S_P2_TURN = 3'd4,
      S_P1_WIN  = 3'd5,
      S_P2_WIN  = 3'd6,
      S_ILLEGAL = 3'd7
   } state_t;

   // y*GRID_W + x; with an 8-wide grid this is a plain bit concatenation.
   function automatic logic [5:0] cell_idx(input logic [2:0] x, input logic [2:0] y);
      return {y, x};
   endfunction

endpackage

// File: rtl/game_fsm_shot_tracker.sv
// Per-player record of which grid cells that player has already fired at.
// Cleared at game start; one cell set per accepted shot.
module shot_tracker
   import game_fsm_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       set,
   input  logic [5:0] set_idx,
   input  logic [5:0] test_idx,
   output logic       tested
);

   logic [CELLS-1:0] map_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         map_q <= '0;
      end else if (clr) begin
         map_q <= '0;
      end else if (set) begin
         map_q[set_idx] <= 1'b1;
      end
   end

   assign tested = map_q[test_idx];

endmodule

// File: rtl/game_fsm.sv
// Turn-based battleship controller: placement handshake, alternating shots,
// one-cycle hit/miss resolution, saturating hit counters and win detection.
module game_fsm
   import game_fsm_pkg::*;
#(
   parameter int WIN_HITS = 17
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        place_done_p1,
   input  logic        place_done_p2,
   input  logic [63:0] ship_map_p1,
   input  logic [63:0] ship_map_p2,
   input  logic        fire,
   input  logic [2:0]  fire_x,
   input  logic [2:0]  fire_y,
   output logic [2:0]  state,
   output logic        hit,
   output logic        miss,
   output logic        shot_reject,
   output logic [6:0]  p1_hits,
   output logic [6:0]  p2_hits
);

   localparam logic [6:0] WIN_CNT = 7'(WIN_HITS);

   state_t     state_q, state_d;
   logic       placed1_q, placed1_d;
   logic       placed2_q, placed2_d;
   logic [5:0] shot_idx_p0, shot_idx_d;
   logic       shooter_p0, shooter_d;
   logic       reject_q, reject_d;
   logic [6:0] p1_cnt_q, p1_cnt_d;
   logic [6:0] p2_cnt_q, p2_cnt_d;

   logic       trk_clr;
   logic       set_p1, set_p2;
   logic       shot_by_p1, shot_by_p2;
   logic [5:0] fire_idx;
   logic       target_bit;

   assign fire_idx = cell_idx(fire_x, fire_y);

   // Shooter 0 is player 1, who targets player 2's fleet.
   assign target_bit = shooter_p0 ? ship_map_p1[shot_idx_p0] : ship_map_p2[shot_idx_p0];

   shot_tracker u_shots_p1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (trk_clr),
      .set      (set_p1),
      .set_idx  (fire_idx),
      .test_idx (fire_idx),
      .tested   (shot_by_p1)
   );

   shot_tracker u_shots_p2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (trk_clr),
      .set      (set_p2),
      .set_idx  (fire_idx),
      .test_idx (fire_idx),
      .tested   (shot_by_p2)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         placed1_q   <= 1'b0;
         placed2_q   <= 1'b0;
         shot_idx_p0 <= '0;
         shooter_p0  <= 1'b0;
         reject_q    <= 1'b0;
         p1_cnt_q    <= '0;
         p2_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         placed1_q   <= placed1_d;
         placed2_q   <= placed2_d;
         shot_idx_p0 <= shot_idx_d;
         shooter_p0  <= shooter_d;
         reject_q    <= reject_d;
         p1_cnt_q    <= p1_cnt_d;
         p2_cnt_q    <= p2_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      placed1_d  = placed1_q;
      placed2_d  = placed2_q;
      shot_idx_d = shot_idx_p0;
      shooter_d  = shooter_p0;
      reject_d   = 1'b0;
      p1_cnt_d   = p1_cnt_q;
      p2_cnt_d   = p2_cnt_q;
      trk_clr    = 1'b0;
      set_p1     = 1'b0;
      set_p2     = 1'b0;
      hit        = 1'b0;
      miss       = 1'b0;

      case (state_q)
         S_IDLE, S_P1_WIN, S_P2_WIN: begin
            if (start) begin
               trk_clr   = 1'b1;
               placed1_d = 1'b0;
               placed2_d = 1'b0;
               p1_cnt_d  = '0;
               p2_cnt_d  = '0;
               state_d   = S_PLACE;
            end
         end

         S_PLACE: begin
            placed1_d = placed1_q | place_done_p1;
            placed2_d = placed2_q | place_done_p2;
            if (placed1_q && placed2_q) begin
               state_d = S_P1_TURN;
            end
         end

         S_P1_TURN: begin
            if (fire) begin
               if (shot_by_p1) begin
                  reject_d = 1'b1;
               end else begin
                  set_p1     = 1'b1;
                  shot_idx_d = fire_idx;
                  shooter_d  = 1'b0;
                  state_d    = S_CHECK;
               end
            end
         end

         S_P2_TURN: begin
            if (fire) begin
               if (shot_by_p2) begin
                  reject_d = 1'b1;
               end else begin
                  set_p2     = 1'b1;
                  shot_idx_d = fire_idx;
                  shooter_d  = 1'b1;
                  state_d    = S_CHECK;
               end
            end
         end

         // Resolve the registered shot; a win outranks handing over the turn.
         S_CHECK: begin
            if (target_bit) begin
               hit = 1'b1;
               if (!shooter_p0) begin
                  if (p1_cnt_q < WIN_CNT) p1_cnt_d = p1_cnt_q + 7'd1;
                  state_d = (p1_cnt_q + 7'd1 == WIN_CNT) ? S_P1_WIN : S_P2_TURN;
               end else begin
                  if (p2_cnt_q < WIN_CNT) p2_cnt_d = p2_cnt_q + 7'd1;
                  state_d = (p2_cnt_q + 7'd1 == WIN_CNT) ? S_P2_WIN : S_P1_TURN;
               end
            end else begin
               miss    = 1'b1;
               state_d = shooter_p0 ? S_P1_TURN : S_P2_TURN;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign state       = state_q;
   assign shot_reject = reject_q;
   assign p1_hits     = p1_cnt_q;
   assign p2_hits     = p2_cnt_q;

endmodule

// File: tb/tb_game_fsm.sv
// Directed bench for game_fsm: stimulus pushes expected pulse records into a
// queue, a negedge monitor pops and compares whenever hit/miss/reject appears.
module tb_game_fsm;
   import game_fsm_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        pd1 = 1'b0;
   logic        pd2 = 1'b0;
   logic        fire = 1'b0;
   logic [2:0]  fx = '0;
   logic [2:0]  fy = '0;
   logic [63:0] map1 = 64'h0000_0000_0000_0600;  // cells (1,1), (2,1)
   logic [63:0] map2 = 64'h8000_0000_0400_0000;  // cells (2,3), (7,7)
   logic [2:0]  state;
   logic        hit, miss, rej;
   logic [6:0]  h1, h2;

   int errors = 0;
   int checks = 0;
   logic [5:0] expq[$];  // {hit, miss, reject, state}

   localparam logic [5:0] E_HIT  = {3'b100, 3'd2};
   localparam logic [5:0] E_MISS = {3'b010, 3'd2};
   localparam logic [5:0] E_REJ  = {3'b001, 3'd3};

   always #5 clk = ~clk;

   game_fsm #(.WIN_HITS(2)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .place_done_p1 (pd1),
      .place_done_p2 (pd2),
      .ship_map_p1   (map1),
      .ship_map_p2   (map2),
      .fire          (fire),
      .fire_x        (fx),
      .fire_y        (fy),
      .state         (state),
      .hit           (hit),
      .miss          (miss),
      .shot_reject   (rej),
      .p1_hits       (h1),
      .p2_hits       (h2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic shoot(input logic [2:0] x, input logic [2:0] y);
      fx   = x;
      fy   = y;
      fire = 1'b1;
      tick();
      fire = 1'b0;
   endtask

   always @(negedge clk) begin
      if (hit || miss || rej) begin
         checks++;
         if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: got hit=%0b miss=%0b rej=%0b state=%0d, expected no pulse",
                     hit, miss, rej, state);
         end else begin
            logic [5:0] e;
            e = expq.pop_front();
            if ({hit, miss, rej, state} !== e) begin
               errors++;
               $display("FAIL pulse: got hit/miss/rej/state=%b/%0d, expected %b/%0d",
                        {hit, miss, rej}, state, e[5:3], e[2:0]);
            end
         end
      end
   end

   initial begin
      repeat (3) tick();
      chk("reset_state", state, 0);
      chk("reset_p1_hits", h1, 0);
      chk("reset_p2_hits", h2, 0);
      chk("reset_hit", hit, 0);
      chk("reset_miss", miss, 0);
      chk("reset_rej", rej, 0);
      rst_n = 1'b1;
      tick();

      start = 1'b1; tick(); start = 1'b0;
      chk("start_to_place", state, 1);
      pd1 = 1'b1; pd2 = 1'b1; tick(); pd1 = 1'b0; pd2 = 1'b0;
      chk("place_flags_set", state, 1);
      tick();
      chk("place_to_p1", state, 3);

      expq.push_back(E_HIT);
      shoot(3'd2, 3'd3);
      chk("p1_hit_check", state, 2);
      tick();
      chk("p1_hit_turn", state, 4);
      chk("p1_hits_1", h1, 1);

      expq.push_back(E_MISS);
      shoot(3'd5, 3'd5); tick();
      chk("p2_miss_turn", state, 3);

      expq.push_back(E_MISS);
      shoot(3'd0, 3'd0); tick();
      chk("p1_miss_turn", state, 4);
      expq.push_back(E_MISS);
      shoot(3'd5, 3'd6); tick();
      chk("p2_miss_turn2", state, 3);

      expq.push_back(E_REJ);
      shoot(3'd0, 3'd0);
      chk("reject_state", state, 3);
      tick();
      chk("reject_hold", state, 3);
      chk("reject_p1_hits", h1, 1);

      expq.push_back(E_MISS);
      shoot(3'd0, 3'd1); tick();
      chk("p1_miss_after_rej", state, 4);
      expq.push_back(E_HIT);
      shoot(3'd1, 3'd1); tick();
      chk("p2_hit_turn", state, 3);
      chk("p2_hits_1", h2, 1);
      expq.push_back(E_MISS);
      shoot(3'd0, 3'd2); tick();
      chk("p1_miss3", state, 4);
      expq.push_back(E_HIT);
      shoot(3'd2, 3'd1); tick();
      chk("p2_win", state, 6);
      chk("p2_hits_win", h2, 2);
      chk("p1_hits_at_win", h1, 1);

      shoot(3'd3, 3'd3); tick();
      chk("win_ignores_fire", state, 6);
      chk("win_p2_hits_hold", h2, 2);

      start = 1'b1; tick(); start = 1'b0;
      chk("restart_place", state, 1);
      chk("restart_p1_hits", h1, 0);
      chk("restart_p2_hits", h2, 0);
      pd1 = 1'b1; pd2 = 1'b1; tick(); pd1 = 1'b0; pd2 = 1'b0;
      tick();
      chk("restart_p1_turn", state, 3);

      shoot(3'd2, 3'd3);
      chk("pre_reset_check", state, 2);
      rst_n = 1'b0;
      #1;
      chk("reset_in_check_state", state, 0);
      chk("reset_in_check_hit", hit, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("reset_in_check_p1_hits", h1, 0);

      shoot(3'd4, 3'd4);
      chk("fire_after_reset", state, 0);
      tick();

      force dut.state_q = S_ILLEGAL;
      #1;
      chk("forced_illegal", state, 7);
      release dut.state_q;
      tick();
      chk("illegal_to_idle", state, 0);

      tick();
      chk("queue_drained", expq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
